reg_access_arbiter: RTL

Shares the single application port of the register bank between `NUM_REQ` requesters (e.g. SPI peripheral, internal sequencer). Accepts one command at a time using round-robin priority and drives it onto the bank port. The bank port carries ena, wr_rdn, addr, wdata and we, and returns rdata, ack and err. The arbiter captures the bank response and returns it to the granted requester as a one-cycle response pulse.

---
 rtl/reg_arb_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/reg_access_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and default constants for the register-bank access arbiter.
// Command fields are sized for the widest supported configuration.
package reg_arb_pkg;

  localparam int DEF_NUM_REQ     = 2;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_REG_W       = 8;
  localparam int DEF_TIMEOUT_CYC = 15;

  localparam int MAX_NUM_REQ = 8;
  localparam int MAX_ADDR_W  = 32;
  localparam int MAX_REG_W   = 32;
  localparam int GRANT_W     = $clog2(MAX_NUM_REQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  wr_rdn;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_REG_W-1:0]  wdata;
    logic [GRANT_W-1:0]    grant;
  } arb_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first set request at or after ptr,
// searching upward with wrap; returns one-hot grant and binary index.
module rr_arbiter #(
  parameter int  N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter sharing one register-bank port between NUM_REQ requesters.
// Define REG_ACCESS_ARB_TIMEOUT_EN to terminate accesses after TIMEOUT_CYC cycles without ack.
module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int REG_W       = DEF_REG_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_wr_rdn,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*REG_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [REG_W-1:0]          rsp_rdata,
  output logic                      rsp_err,
  output logic                      bank_ena,
  output logic                      bank_wr_rdn,
  output logic                      bank_we,
  output logic [ADDR_W-1:0]         bank_addr,
  output logic [REG_W-1:0]          bank_wdata,
  input  logic [REG_W-1:0]          bank_rdata,
  input  logic                      bank_ack,
  input  logic                      bank_err
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t        state_reg;
  arb_cmd_t          cmd_reg;
  logic [IW-1:0]     rr_ptr_reg;
  logic [REG_W-1:0]  rsp_rdata_reg;
  logic              rsp_err_reg;

  logic [NUM_REQ-1:0] win_gnt;
  logic [IW-1:0]      win_idx;
  logic               win_any;
  logic [IW-1:0]      grant_idx;
  logic               in_access;
  logic               cmd_unused;

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [REG_W-1:0]  wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_wdata[gi*REG_W +: REG_W];
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr_reg),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

`ifdef REG_ACCESS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_reg;
`else
  localparam int TIMEOUT_UNUSED = TIMEOUT_CYC;
`endif

  assign grant_idx  = cmd_reg.grant[IW-1:0];
  // Only the low ADDR_W/REG_W/IW bits of the wide command fields carry data.
  assign cmd_unused = ^cmd_reg;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg     <= IDLE;
      cmd_reg       <= '0;
      rr_ptr_reg    <= '0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
`ifdef REG_ACCESS_ARB_TIMEOUT_EN
      cnt_reg       <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_any) begin
            cmd_reg.wr_rdn <= req_wr_rdn[win_idx];
            cmd_reg.addr   <= MAX_ADDR_W'(addr_arr[win_idx]);
            cmd_reg.wdata  <= MAX_REG_W'(wdata_arr[win_idx]);
            cmd_reg.grant  <= GRANT_W'(win_idx);
            state_reg      <= ACCESS;
`ifdef REG_ACCESS_ARB_TIMEOUT_EN
            cnt_reg        <= '0;
`endif
          end
        end
        ACCESS: begin
          // A late ack still wins over the timeout in the same cycle.
          if (bank_ack) begin
            rsp_rdata_reg <= cmd_reg.wr_rdn ? '0 : bank_rdata;
            rsp_err_reg   <= bank_err;
            state_reg     <= RESP;
          end
`ifdef REG_ACCESS_ARB_TIMEOUT_EN
          else if (cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b1;
            state_reg     <= RESP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
`endif
        end
        RESP: begin
          rr_ptr_reg <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_access   = (state_reg == ACCESS);
  assign bank_ena    = in_access;
  assign bank_wr_rdn = in_access & cmd_reg.wr_rdn;
  assign bank_we     = in_access & cmd_reg.wr_rdn;
  assign bank_addr   = in_access ? cmd_reg.addr[ADDR_W-1:0] : '0;
  assign bank_wdata  = in_access ? cmd_reg.wdata[REG_W-1:0] : '0;

  // Acceptance is masked while reset is held so every output reads 0 in reset.
  assign req_ready = ((state_reg == IDLE) && rstb) ? win_gnt : '0;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
    assign rsp_valid[gi] = (state_reg == RESP) && (grant_idx == IW'(gi));
  end

  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule
